// File: rtl/qc_ldpc_enc.sv
// Systematic QC-LDPC encoder: echoes KB info sub-blocks, then emits MB parity sub-blocks.
// Latency: 1 cycle from accepted input to output register; parity follows the last info with no bubbles.
// Backpressure: single output register; in_ready drops whenever it is occupied and not draining.
module qc_ldpc_enc #(
    parameter int Z  = 5,
    parameter int KB = 4,
    parameter int MB = 2,
    parameter int SW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MB*KB*SW-1:0]  shift_tab,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Z-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Z-1:0]         out_data,
    output logic                 out_par,
    output logic                 out_last,
    output logic                 busy
);

    localparam int KCW = (KB > 1) ? $clog2(KB) : 1;
    localparam int PCW = (MB > 1) ? $clog2(MB) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [KCW-1:0]   kc_q, kc_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic [Z-1:0]     acc_q [MB];
    logic [Z-1:0]     acc_d [MB];
    logic             out_valid_q, out_valid_d;
    logic [Z-1:0]     out_data_q, out_data_d;
    logic             out_par_q, out_par_d;
    logic             out_last_q, out_last_d;
    logic             reg_free;

    // Circulant multiply: result bit i takes u[(i+s) mod Z]; the all-ones entry is the null circulant.
    function automatic logic [Z-1:0] rot(input logic [Z-1:0] u, input logic [SW-1:0] s);
        logic [2*Z-1:0] dbl;
        int             sh;
        if (s == {SW{1'b1}}) begin
            return '0;
        end
        sh  = int'(s) % Z;
        dbl = {u, u};
        dbl = dbl >> sh;
        return dbl[Z-1:0];
    endfunction

    assign reg_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ACCUM) && reg_free;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_par   = out_par_q;
    assign out_last  = out_last_q;
    assign busy      = (kc_q != '0) || (state_q == FLUSH);

    // Next-state: accept/echo info and fold into accumulators, or stream parity out in FLUSH.
    always_comb begin
        state_d     = state_q;
        kc_d        = kc_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_par_d   = out_par_q;
        out_last_d  = out_last_q;
        for (int j = 0; j < MB; j++) begin
            acc_d[j] = acc_q[j];
        end

        // The consumer took the current word; a reload below overrides this.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == ACCUM) begin
            if (in_valid && in_ready) begin
                out_data_d  = in_data;
                out_par_d   = 1'b0;
                out_last_d  = 1'b0;
                out_valid_d = 1'b1;
                for (int j = 0; j < MB; j++) begin
                    acc_d[j] = acc_q[j] ^
                        rot(in_data, shift_tab[(j*KB + int'(kc_q))*SW +: SW]);
                end
                if (kc_q == KCW'(KB-1)) begin
                    kc_d    = '0;
                    pc_d    = '0;
                    state_d = FLUSH;
                end else begin
                    kc_d = kc_q + KCW'(1);
                end
            end
        end else begin
            if (reg_free) begin
                out_data_d  = acc_q[pc_q];
                out_par_d   = 1'b1;
                out_last_d  = (pc_q == PCW'(MB-1));
                out_valid_d = 1'b1;
                if (pc_q == PCW'(MB-1)) begin
                    for (int j = 0; j < MB; j++) begin
                        acc_d[j] = '0;
                    end
                    pc_d    = '0;
                    state_d = ACCUM;
                end else begin
                    pc_d = pc_q + PCW'(1);
                end
            end
        end
    end

    // State registers; reset discards any partial codeword.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            kc_q        <= '0;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_last_q  <= 1'b0;
            for (int j = 0; j < MB; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            kc_q        <= kc_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_last_q  <= out_last_d;
            for (int j = 0; j < MB; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

endmodule

// File: doc/qc_ldpc_enc.md
Name: qc_ldpc_enc

Overview:
- Systematic quasi-cyclic LDPC encoder; the transmit-side counterpart of the decoder's variable/check cyclic-shift network.
- Accepts one message of KB information sub-blocks, each Z bits wide. Each sub-block is passed through to the output immediately.
- Each sub-block is also cyclically rotated into MB parity accumulators using a run-time shift table.
- After the last information sub-block, the block emits the MB parity sub-blocks. Output is a valid/ready stream of Z-bit sub-blocks feeding the channel/test harness.

Parameters:
- Z, 5, circulant size (sub-block width in bits)
- KB, 4, information sub-blocks per codeword
- MB, 2, parity sub-blocks per codeword
- SW, 3, shift-entry width in bits; the all-ones value marks a null (zero) circulant

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- shift_tab  input  MB*KB*SW  shift table; entry (j,k) occupies bits [(j*KB+k)*SW +: SW]
- in_valid  input  1  information sub-block valid
- in_ready  output  1  information sub-block accepted when in_valid && in_ready
- in_data  input  Z  information sub-block
- out_valid  output  1  output sub-block valid
- out_ready  input  1  downstream ready
- out_data  output  Z  output sub-block (information or parity)
- out_par  output  1  out_data is a parity sub-block
- out_last  output  1  final sub-block of the codeword
- busy  output  1  a codeword is in progress (information count > 0, or FLUSH state)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = ACCUM; info count kc = 0; parity count pc = 0.
  - All MB accumulators are 0.
  - out_valid = 0, out_data = 0, out_par = 0, out_last = 0, busy = 0.
- Rotation rule: rot(u,s)[i] = u[(i+s) mod Z] for i = 0..Z-1.
  - Entry value all-ones contributes 0 (null circulant).
  - Any other entry value s ≥ Z is reduced mod Z.
- Output register: single stage. It is free when !out_valid || out_ready.
  - out_valid clears on out_valid && out_ready unless the register is reloaded in the same cycle.
- ACCUM state:
  - in_ready = register free.
  - On accept with kc = k:
    - out_data <= in_data, out_par <= 0, out_last <= 0, out_valid <= 1.
    - For every j: acc[j] <= acc[j] ^ rot(in_data, entry(j,k)).
    - kc <= kc + 1.
  - Latency from input to output is 1 cycle.
  - When k = KB-1 is accepted: kc <= 0, pc <= 0, state <= FLUSH.
- FLUSH state:
  - in_ready = 0.
  - Each cycle the register is free:
    - out_data <= acc[pc], out_par <= 1, out_last <= (pc == MB-1), out_valid <= 1, pc <= pc + 1.
  - After the pc = MB-1 load: all acc <= 0, pc <= 0, state <= ACCUM.
  - The first information sub-block of the next codeword can be accepted in the following cycle, provided the register is free.
- Throughput: one sub-block per cycle under continuous out_ready. A codeword takes KB+MB output cycles; there are no bubbles between codewords.
- Backpressure: while out_valid && !out_ready, out_data, out_par and out_last hold stable, and in_ready = 0.
- shift_tab is read at each information accept. It must be held stable while busy = 1. Changing it mid-codeword is permitted, but the parity produced is unspecified.
- Reset asserted mid-codeword: the partial codeword is discarded and all state returns to reset values immediately. There is no partial parity output.
- in_valid is ignored in FLUSH. in_data is ignored when it is not accepted.

Test Plan:
- Basic encode: Z=5, KB=4, MB=2, SW=3. Entry(0,0) = 1, entry(1,0) = 0, all other entries 7. Inputs 5'b00001, 0, 0, 0 with out_ready = 1 → outputs 00001, 00000, 00000, 00000, then parity 10000 and parity 00001. out_par = 1 on the last two outputs; out_last = 1 on the sixth.
- All-null table: every entry 7, arbitrary inputs (e.g. 5'b10110, 5'b01101, 5'b11111, 5'b00011) → inputs echoed unchanged, both parity sub-blocks = 00000.
- Accumulation and wrap: all entries 4. Inputs 00001, 00010, 00100, 01000 (rotations 00010, 00100, 01000, 10000) → both parities = 11110. Also a shift entry of 6 behaves as shift 1.
- Backpressure: hold out_ready = 0 for 3 cycles at the first parity → out_data = parity stays stable, in_ready = 0, no sub-block lost or duplicated. Total of 6 handshakes per codeword.
- Back-to-back codewords: continuous in_valid and out_ready over 3 codewords → 18 outputs in 18 consecutive cycles after the first. Parities match a reference model, and accumulators clear between codewords.
- Reset mid-operation: assert rst after 2 information accepts → out_valid = 0 and busy = 0 immediately. A subsequent full codeword matches the reference model, with no residue from the aborted one.
